// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the CPU clock controller: FSM states and board mode switch values.
// The state encoding is exported on state_o, so these values are externally visible.
package clk_ctrl_pkg;

    localparam logic [1:0] ST_HALT      = 2'b00;
    localparam logic [1:0] ST_RUN       = 2'b01;
    localparam logic [1:0] ST_STEP_WAIT = 2'b10;
    localparam logic [1:0] ST_STEP_FIRE = 2'b11;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // State selected purely by the mode switches; the reserved code 11 parks in HALT.
    function automatic logic [1:0] mode_target(input logic [1:0] mode);
        case (mode)
            MODE_RUN:  return ST_RUN;
            MODE_STEP: return ST_STEP_WAIT;
            default:   return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
// evt_o rises 2+DEB_CYCLES cycles after a clean press; no backpressure, pulses are never queued.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic evt_o
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          evt_q;

    // cnt_q counts consecutive synchronised samples that disagree with the accepted level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            evt_q  <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                evt_q   <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign evt_o   = evt_q;

endmodule

// File: rtl/clk_ctrl.sv
// Run/halt/single-step controller producing a registered one-cycle CPU enable and a slow probe clock.
// tick_o lags the terminal-count cycle by one clock; no backpressure, step presses outside STEP_WAIT are dropped.
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int          DEB_CYCLES  = 1_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mode_i,
    input  logic             step_btn_i,
    input  logic             div_load_i,
    input  logic [CNT_W-1:0] div_val_i,
    output logic             tick_o,
    output logic             slow_clk_o,
    output logic [1:0]       state_o,
    output logic [15:0]      tick_count_o
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             tick_q;
    logic             slow_q;
    logic [15:0]      tick_cnt_q;
    logic             step_evt;
    logic             btn_level;
    logic             term_cnt;
    logic             fire;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .btn_i  (step_btn_i),
        .level_o(btn_level),
        .evt_o  (step_evt)
    );

    assign term_cnt = (state_q == ST_RUN) && (cnt_q == div_q);
    // A divisor load restarts the period, so it suppresses a coincident terminal-count tick.
    assign fire = (term_cnt && !div_load_i) || (state_q == ST_STEP_FIRE);

    always_comb begin
        state_d = mode_target(mode_i);
        if ((state_q == ST_STEP_WAIT) && (mode_i == MODE_STEP) && step_evt) begin
            state_d = ST_STEP_FIRE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_HALT;
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            tick_q     <= 1'b0;
            slow_q     <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= fire;
            if (fire) begin
                slow_q     <= ~slow_q;
                tick_cnt_q <= tick_cnt_q + 16'd1;
            end
            if (div_load_i) begin
                div_q <= div_val_i;
                cnt_q <= '0;
            end else if ((state_q == ST_RUN) && (state_d == ST_RUN) && !term_cnt) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign tick_o       = tick_q;
    assign slow_clk_o   = slow_q;
    assign state_o      = state_q;
    assign tick_count_o = tick_cnt_q;

    logic unused_level;
    assign unused_level = btn_level;

endmodule

// File: tb/tb_clk_ctrl.sv
// Self-checking bench for clk_ctrl against a cycle-level behavioural model with randomised stimulus.
module tb_clk_ctrl;

    localparam int DEB = 4;

    logic        clk_i      = 1'b0;
    logic        rst_i      = 1'b1;
    logic [1:0]  mode_i     = 2'b00;
    logic        step_btn_i = 1'b0;
    logic        div_load_i = 1'b0;
    logic [31:0] div_val_i  = '0;
    logic        tick_o;
    logic        slow_clk_o;
    logic [1:0]  state_o;
    logic [15:0] tick_count_o;

    clk_ctrl #(
        .CNT_W      (32),
        .DEFAULT_DIV(3),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mode_i      (mode_i),
        .step_btn_i  (step_btn_i),
        .div_load_i  (div_load_i),
        .div_val_i   (div_val_i),
        .tick_o      (tick_o),
        .slow_clk_o  (slow_clk_o),
        .state_o     (state_o),
        .tick_count_o(tick_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: run progress is "cycles spent in RUN since the period restarted".
    logic [1:0]  m_st;
    longint      m_div;
    longint      m_age;
    logic        m_tick;
    logic        m_slow;
    logic [15:0] m_count;
    logic        m_lvl;
    logic        m_evt_prev;
    bit          raw_q[$];
    bit          syn_q[$];

    task automatic model_edge();
        logic [1:0] nxt;
        bit syn, flip, new_evt, fire;
        if (rst_i) begin
            m_st = 2'b00; m_div = 3; m_age = 0; m_tick = 0; m_slow = 1; m_count = 0;
            m_lvl = 0; m_evt_prev = 0;
            raw_q.delete(); syn_q.delete();
            return;
        end
        fire = (m_st == 2'b01 && !div_load_i && (m_age % (m_div + 1)) == m_div) || (m_st == 2'b11);
        case (mode_i)
            2'b01:   nxt = 2'b01;
            2'b10:   nxt = (m_st == 2'b10 && m_evt_prev) ? 2'b11 : 2'b10;
            default: nxt = 2'b00;
        endcase
        m_tick = fire;
        if (fire) begin
            m_slow  = !m_slow;
            m_count = m_count + 16'd1;
        end
        if (div_load_i) begin
            m_div = longint'(div_val_i);
            m_age = 0;
        end else if (m_st == 2'b01 && nxt == 2'b01) m_age++;
        else m_age = 0;
        m_st = nxt;
        // Button: sample seen two edges late; accept after DEB identical disagreeing samples.
        syn = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
        raw_q.push_back(step_btn_i);
        if (raw_q.size() > 2) void'(raw_q.pop_front());
        syn_q.push_back(syn);
        if (syn_q.size() > DEB) void'(syn_q.pop_front());
        new_evt = 0;
        if (syn_q.size() == DEB) begin
            flip = 1;
            foreach (syn_q[i]) if (syn_q[i] == m_lvl) flip = 0;
            if (flip) begin
                m_lvl = !m_lvl;
                new_evt = m_lvl;
                syn_q.delete();
            end
        end
        m_evt_prev = new_evt;
    endtask

    task automatic clk_step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1; mode_i = 2'b00; step_btn_i = 0; div_load_i = 0; div_val_i = '0;
        clk_step();
        clk_step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tick_o, slow_clk_o, state_o, tick_count_o} !== {1'b0, 1'b1, 2'b00, 16'd0}) begin
            errors++;
            $display("FAIL reset_values: got tick=%0b slow=%0b st=%0d cnt=%0d want 0 1 0 0",
                     tick_o, slow_clk_o, state_o, tick_count_o);
        end
    endtask

    task automatic test_run();
        int pulses = 0, last = -1;
        do_reset();
        mode_i = 2'b01;
        for (int c = 0; c < 20; c++) begin
            clk_step();
            checks++;
            if ({tick_o, slow_clk_o, state_o, tick_count_o} !== {m_tick, m_slow, m_st, m_count}) begin
                errors++;
                $display("FAIL run_model c=%0d: got %0b %0b %0d %0d want %0b %0b %0d %0d", c,
                         tick_o, slow_clk_o, state_o, tick_count_o, m_tick, m_slow, m_st, m_count);
            end
            if (tick_o) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != 4) begin
                        errors++;
                        $display("FAIL run_period: got %0d want 4", c - last);
                    end
                end
                last = c;
                pulses++;
            end
        end
        checks++;
        if (pulses < 4 || pulses > 5 || tick_count_o !== 16'(pulses)) begin
            errors++;
            $display("FAIL run_count: pulses=%0d tick_count=%0d want 4..5 and equal", pulses, tick_count_o);
        end
    endtask

    task automatic test_step();
        int pulses;
        do_reset();
        mode_i = 2'b10;
        for (int ph = 0; ph < 2; ph++) begin
            pulses = 0;
            for (int c = 0; c < 40; c++) begin
                step_btn_i = (ph == 0) ? (c < 10) : (c < 2);
                clk_step();
                checks++;
                if ({tick_o, slow_clk_o, state_o, tick_count_o} !== {m_tick, m_slow, m_st, m_count}) begin
                    errors++;
                    $display("FAIL step_model ph=%0d c=%0d: got %0b %0b %0d %0d want %0b %0b %0d %0d", ph, c,
                             tick_o, slow_clk_o, state_o, tick_count_o, m_tick, m_slow, m_st, m_count);
                end
                if (tick_o) pulses++;
            end
            checks++;
            if (pulses != ((ph == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL step_pulses ph=%0d: got %0d want %0d", ph, pulses, (ph == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_div_load();
        do_reset();
        mode_i = 2'b01;
        clk_step();
        clk_step();
        div_load_i = 1; div_val_i = 32'd0;
        clk_step();
        div_load_i = 0;
        for (int c = 0; c < 6; c++) begin
            clk_step();
            checks++;
            if (tick_o !== 1'b1 || m_tick !== 1'b1) begin
                errors++;
                $display("FAIL div0_every_cycle c=%0d: got %0b model %0b want 1", c, tick_o, m_tick);
            end
        end
        div_load_i = 1; div_val_i = 32'd7;
        clk_step();
        div_load_i = 0;
        checks++;
        if (tick_o !== 1'b0) begin
            errors++;
            $display("FAIL load_at_tc: got tick=%0b want 0", tick_o);
        end
        for (int k = 1; k <= 8; k++) begin
            clk_step();
            checks++;
            if (tick_o !== (k == 8) || m_tick !== (k == 8)) begin
                errors++;
                $display("FAIL div7_period k=%0d: got %0b model %0b want %0b", k, tick_o, m_tick, k == 8);
            end
        end
    endtask

    task automatic test_mode_exit();
        int guard = 0;
        do_reset();
        mode_i = 2'b01;
        do begin
            clk_step();
            guard++;
        end while (!tick_o && guard < 20);
        checks++;
        if (!tick_o) begin
            errors++;
            $display("FAIL exit_first_tick: got no tick in 20 cycles want tick");
        end
        repeat (3) clk_step();
        mode_i = 2'b00;
        clk_step();
        checks++;
        if (tick_o !== 1'b1 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL exit_final_tick: got tick=%0b st=%0d want 1 0", tick_o, state_o);
        end
        for (int c = 0; c < 8; c++) begin
            clk_step();
            checks++;
            if (tick_o !== 1'b0 || state_o !== 2'b00) begin
                errors++;
                $display("FAIL exit_quiet c=%0d: got tick=%0b st=%0d want 0 0", c, tick_o, state_o);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int wait_cyc = 0;
        do_reset();
        mode_i = 2'b01;
        clk_step();
        div_load_i = 1; div_val_i = 32'd9;
        clk_step();
        div_load_i = 0;
        clk_step();
        clk_step();
        rst_i = 1;
        clk_step();
        rst_i = 0;
        checks++;
        if ({tick_o, slow_clk_o, state_o, tick_count_o} !== {1'b0, 1'b1, 2'b00, 16'd0}) begin
            errors++;
            $display("FAIL midrun_reset: got %0b %0b %0d %0d want 0 1 0 0",
                     tick_o, slow_clk_o, state_o, tick_count_o);
        end
        do begin
            clk_step();
            wait_cyc++;
        end while (!tick_o && wait_cyc < 30);
        checks++;
        if (wait_cyc != 5) begin
            errors++;
            $display("FAIL midrun_div_restored: got first tick after %0d cycles want 5", wait_cyc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) step_btn_i = !step_btn_i;
            div_load_i = ($urandom_range(0, 39) == 0);
            div_val_i  = 32'($urandom_range(0, 6));
            rst_i      = ($urandom_range(0, 499) == 0);
            clk_step();
            checks++;
            if ({tick_o, slow_clk_o, state_o, tick_count_o} !== {m_tick, m_slow, m_st, m_count}) begin
                errors++;
                $display("FAIL random_model c=%0d: got %0b %0b %0d %0d want %0b %0b %0d %0d", c,
                         tick_o, slow_clk_o, state_o, tick_count_o, m_tick, m_slow, m_st, m_count);
            end
        end
        rst_i = 0; div_load_i = 0; step_btn_i = 0;
    endtask

    task automatic test_wrap();
        int pulses = 0, c = 0;
        do_reset();
        mode_i = 2'b01;
        div_load_i = 1; div_val_i = 32'd0;
        clk_step();
        div_load_i = 0;
        while (pulses < 65536 && c < 70000) begin
            clk_step();
            c++;
            checks++;
            if ({tick_o, slow_clk_o, state_o, tick_count_o} !== {m_tick, m_slow, m_st, m_count}) begin
                errors++;
                $display("FAIL wrap_model c=%0d: got %0b %0b %0d %0d want %0b %0b %0d %0d", c,
                         tick_o, slow_clk_o, state_o, tick_count_o, m_tick, m_slow, m_st, m_count);
            end
            if (tick_o) pulses++;
        end
        checks++;
        if (pulses != 65536 || tick_count_o !== 16'd0) begin
            errors++;
            $display("FAIL wrap_zero: got pulses=%0d tick_count=%0d want 65536 0", pulses, tick_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_div_load();
        test_mode_exit();
        test_reset_mid_run();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_ctrl.md
Name: clk_ctrl

Overview:
Run/step/halt controller for the CPU clock of the single-cycle FPGA processor. It owns a programmable divider counter and issues a one-cycle processor enable (tick_o) plus a 50%-duty slow clock for LEDs/probes. Free-run, halt and debounced single-step come from board switches and a push-button. It sits between the board clock/inputs and the processor top level.

Parameters:
CNT_W, 32, width of divider counter and divisor register
DEFAULT_DIV, 50_000_000, divisor loaded at reset (tick period = DIV+1 clk_i cycles)
DEB_CYCLES, 1_000_000, clk_i cycles a synchronised button level must be stable to be accepted

Ports:
clk_i  in  1  board clock, sole clock
rst_i  in  1  reset, synchronous, active-high
mode_i  in  2  00 HALT, 01 RUN, 10 STEP, 11 reserved (treated as HALT)
step_btn_i  in  1  raw asynchronous push-button, active-high
div_load_i  in  1  one-cycle strobe: load div_val_i into divisor register
div_val_i  in  CNT_W  new divisor value
tick_o  out  1  one-cycle processor enable pulse
slow_clk_o  out  1  toggles on every tick_o
state_o  out  2  current FSM state encoding
tick_count_o  out  16  ticks issued since reset

Behaviour:
- Reset (rst_i high at clk_i edge): state=HALT, cnt=0, div_q=DEFAULT_DIV, tick_o=0, slow_clk_o=1, tick_count_o=0, debouncer cleared (stable level 0, counter 0).
- Reset mid-operation behaves identically; no pending step or partial count survives.
- Button path: 2-flop synchroniser -> debounce counter; accepted level changes only after DEB_CYCLES consecutive identical samples; rising edge of accepted level = step_evt (one cycle).
- States: HALT(00), RUN(01), STEP_WAIT(10), STEP_FIRE(11).
- HALT: mode 01 -> RUN; mode 10 -> STEP_WAIT; else stay. cnt held at 0.
- RUN: cnt increments each cycle; at cnt==div_q cnt->0 and tick fires. mode != 01 -> HALT or STEP_WAIT per mode, cnt cleared.
- STEP_WAIT: step_evt -> STEP_FIRE. mode 01 -> RUN; mode 00/11 -> HALT. Mode change takes priority over step_evt.
- STEP_FIRE: lasts exactly one cycle, fires tick, returns to STEP_WAIT (or per mode as above).
- tick_o is registered: asserted one cycle after the cycle in which state==RUN with cnt==div_q, or state==STEP_FIRE. Period in RUN = div_q+1 cycles; div_q=0 gives a tick every cycle.
- Mode sampled every cycle; a terminal count coinciding with a mode change out of RUN still fires (state still RUN that cycle).
- div_load_i: div_q<=div_val_i, cnt<=0 same edge; if coincident with terminal count, load wins and no tick fires. Loads accepted in any state.
- slow_clk_o toggles in the same cycle tick_o rises.
- tick_count_o increments on each tick_o, wraps 16'hFFFF -> 0.
- Step presses while in RUN or HALT are discarded, not queued.

Decomposition:
- Shared package clk_ctrl_pkg: state encodings, mode encodings (MODE_HALT/RUN/STEP).
- Sub-module btn_debounce (synchroniser + stability counter + rising-edge pulse), parameterised by DEB_CYCLES; instantiated once.

Test Plan (DEB_CYCLES=4, DEFAULT_DIV=3):
- Reset then mode=01 for 20 cycles -> tick_o every 4 cycles, slow_clk_o period 8 cycles, tick_count_o=4 or 5 depending on alignment, counted exactly against model.
- mode=10, button high 10 cycles then low -> exactly one tick_o; button glitch of 2 cycles -> no tick.
- RUN, div_load_i with div_val_i=0 -> tick_o every cycle; load with 7 at terminal count -> no tick that cycle, next tick 8 cycles later.
- RUN, switch mode to 00 on terminal-count cycle -> final tick fires, then none; state_o=00.
- Assert rst_i mid-RUN with cnt=2 -> next cycle all outputs at reset values, div_q back to 3.
- Drive 65536 ticks with div=0 -> tick_count_o wraps to 0.
